// File: rtl/muldiv_sequencer.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Build option: define MULDIV_FAST_MULT_EN for a single-cycle multiply path (divide timing unchanged).
module muldiv_sequencer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic        o_op_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    function automatic logic [31:0] f_abs(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [63:0] r_acc;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_div;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_trial;
    logic [63:0] w_mag_prod;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_accept = i_op_valid && (r_state == S_IDLE);

    // r_acc holds {partial product, multiplier} when multiplying and {remainder, dividend/quotient} when dividing
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_div_shift = r_acc[63:31];
    assign w_div_trial = w_div_shift - {1'b0, r_a};

`ifdef MULDIV_FAST_MULT_EN
    assign w_mag_prod = {32'd0, r_a} * {32'd0, r_acc[31:0]};
`else
    assign w_mag_prod = r_acc;
`endif
    assign w_prod = r_neg_q ? (64'd0 - w_mag_prod) : w_mag_prod;
    assign w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_op)
`ifdef MULDIV_FAST_MULT_EN
                        OP_MULT, OP_MULTU: w_next_state = S_FIXUP;
`else
                        OP_MULT, OP_MULTU: w_next_state = S_MUL;
`endif
                        OP_DIV, OP_DIVU:   w_next_state = S_DIV;
                        default:           w_next_state = S_IDLE;
                    endcase
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == 5'd31) begin
                    w_next_state = S_FIXUP;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_FIXUP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand capture, iteration steps and HI/LO write-back
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_acc    <= 64'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= (r_state == S_FIXUP);
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 5'd0;
                    if (w_accept) begin
                        case (i_op)
                            OP_MULT, OP_MULTU: begin
                                r_a      <= f_abs(i_rs_data, i_op == OP_MULT);
                                r_acc    <= {32'd0, f_abs(i_rt_data, i_op == OP_MULT)};
                                r_neg_q  <= (i_op == OP_MULT) && (i_rs_data[31] ^ i_rt_data[31]);
                                r_neg_r  <= 1'b0;
                                r_is_div <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_a      <= f_abs(i_rt_data, i_op == OP_DIV);
                                r_acc    <= {32'd0, f_abs(i_rs_data, i_op == OP_DIV)};
                                // Divide by zero keeps the all-ones quotient un-negated
                                r_neg_q  <= (i_op == OP_DIV) && (i_rs_data[31] ^ i_rt_data[31])
                                            && (i_rt_data != 32'd0);
                                r_neg_r  <= (i_op == OP_DIV) && i_rs_data[31];
                                r_is_div <= 1'b1;
                            end
                            OP_MTHI: r_hi <= i_rs_data;
                            OP_MTLO: r_lo <= i_rs_data;
                            default: begin
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_acc <= {(w_div_trial[32] ? w_div_shift[31:0] : w_div_trial[31:0]),
                              r_acc[30:0], ~w_div_trial[32]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIXUP: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_op_ready = (r_state == S_IDLE);
    assign o_done     = r_done;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic HI/LO reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_op_valid (op_valid),
        .i_op       (op),
        .i_rs_data  (rs),
        .i_rt_data  (rt),
        .o_op_ready (op_ready),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what HI/LO should hold after an operation completes
    function automatic void model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd0: begin
                sp = longint'(sa) * longint'(sb);
                up = sp;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: begin
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1) return MUL_LAT;
        else if (o == 3'd2 || o == 3'd3) return 33;
        else return 0;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          exp_lat;
        int          n;
        bit          hold_ok;
        old_hi  = m_hi;
        old_lo  = m_lo;
        exp_lat = lat_of(o);
        model_apply(o, a, b);
        op_valid = 1'b1; op = o; rs = a; rt = b;
        tick();
        op_valid = 1'b0; op = 3'($urandom); rs = $urandom; rt = $urandom;
        if (exp_lat == 0) begin
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                bad++;
                $display("FAIL %s imm: busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                         name, busy, done, hi, lo, m_hi, m_lo);
            end
        end else begin
            n = 0;
            hold_ok = 1'b1;
            while (done !== 1'b1 && n < 100) begin
                if (busy !== 1'b1 || op_ready !== 1'b0 || hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
                tick();
                n++;
            end
            total++;
            if (!hold_ok) begin
                bad++;
                $display("FAIL %s hold: busy/hi/lo changed during operation, want hi=%h lo=%h", name, old_hi, old_lo);
            end
            total++;
            if (n != exp_lat) begin
                bad++;
                $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
            end
            total++;
            if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s result: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0", name, hi, lo, busy, m_hi, m_lo);
            end
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s pulse: done=%b busy=%b ready=%b want 0 0 1", name, done, busy, op_ready);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b1; op = 3'd5; rs = 32'hDEAD_BEEF; rt = 32'd0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || op_ready !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b ready=%b hi=%h lo=%h want 0 0 1 0 0", busy, done, op_ready, hi, lo);
        end
        reset = 1'b0; op_valid = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_spec_vectors();
        logic [2:0]  vo [7] = '{3'd1, 3'd0, 3'd2, 3'd2, 3'd3, 3'd2, 3'd5};
        logic [31:0] va [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000,
                                32'd100, 32'hFFFF_FFFB, 32'h1234_5678};
        logic [31:0] vb [7] = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0002, 32'hFFFF_FFFF,
                                32'd0, 32'd0, 32'd0};
        logic [31:0] eh [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
                                32'h0000_0064, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] el [7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        for (int i = 0; i < 7; i++) begin
            run_op(vo[i], va[i], vb[i], $sformatf("vec%0d", i));
            total++;
            if (hi !== eh[i] || lo !== el[i]) begin
                bad++;
                $display("FAIL vec%0d const: hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        model_apply(3'd3, 32'd100, 32'd0);
        op_valid = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd0;
        tick();
        op = 3'd5; rs = 32'hAAAA_5555;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n != 33 || hi !== 32'h0000_0064 || lo !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL busy_ignore div: cycles=%0d hi=%h lo=%h want 33 00000064 ffffffff", n, hi, lo);
        end
        tick();
        op_valid = 1'b0;
        model_apply(3'd5, 32'hAAAA_5555, 32'd0);
        total++;
        if (lo !== 32'hAAAA_5555 || hi !== 32'h0000_0064 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore late accept: hi=%h lo=%h done=%b busy=%b want 00000064 aaaa5555 0 0",
                     hi, lo, done, busy);
        end
    endtask

    task automatic test_mthi_mid_div();
        int n;
        model_apply(3'd2, 32'd1000, 32'd7);
        op_valid = 1'b1; op = 3'd2; rs = 32'd1000; rt = 32'd7;
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        op_valid = 1'b1; op = 3'd4; rs = 32'h0BAD_F00D;
        tick();
        op_valid = 1'b0;
        n = 6;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n != 33 || hi !== m_hi || lo !== m_lo) begin
            bad++;
            $display("FAIL mthi_mid_div: cycles=%0d hi=%h lo=%h want 33 hi=%h lo=%h", n, hi, lo, m_hi, m_lo);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        bit saw_done;
        run_op(3'd4, 32'h1111_1111, 32'd0, "pre_mthi");
        run_op(3'd5, 32'h2222_2222, 32'd0, "pre_mtlo");
        op_valid = 1'b1; op = 3'd2; rs = 32'hFFFF_0000; rt = 32'd3;
        tick();
        op_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        total++;
        if (busy !== 1'b0 || op_ready !== 1'b1 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_div: busy=%b ready=%b hi=%h lo=%h done=%b want 0 1 0 0 0", busy, op_ready, hi, lo, done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL reset_mid_div ghost: got done/busy after reset, want none");
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            run_op(o, a, b, $sformatf("rnd%0d", i));
        end
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        test_reset();
        test_spec_vectors();
        test_busy_ignore();
        test_mthi_mid_div();
        test_reset_mid_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  an operation is presented this cycle.
REQ-005 op_ready  output  1  the block can accept an operation this cycle; equals !busy.
REQ-006 op  input  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-007 rs_data  input  32  first operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-008 rt_data  input  32  second operand: multiplier or divisor.
REQ-009 busy  output  1  a multiply or divide is in progress.
REQ-010 done  output  1  one-cycle pulse; HI/LO were updated by a MULT, MULTU, DIV or DIVU at the preceding edge.
REQ-011 hi  output  32  current HI register.
REQ-012 lo  output  32  current LO register.

Function
REQ-013 An operation SHALL be accepted on the rising edge where op_valid=1 and busy=0; op_valid while busy=1 SHALL be ignored with no side effect.
REQ-014 The state machine SHALL have the states IDLE, MUL (32 iterations), DIV (32 iterations) and FIXUP.
REQ-015 Transitions: IDLE->MUL on an accepted MULT/MULTU; IDLE->DIV on an accepted DIV/DIVU; MUL/DIV->FIXUP after the 32nd iteration; FIXUP->IDLE always.
REQ-016 At acceptance (edge E0) the block SHALL latch operand magnitudes, the signed/unsigned flag and the result-negation flags internally; rs_data and rt_data MAY change after E0.
REQ-017 MUL and DIV SHALL perform one shift-add or restoring-subtract step per cycle, on edges E1..E32.
REQ-018 FIXUP at edge E33 SHALL apply sign correction and write hi/lo; busy SHALL be 1 from after E0 until after E33.
REQ-019 done SHALL be 1 exactly during the cycle after E33.
REQ-020 MULT and MULTU SHALL produce the full 64-bit product, two's-complement for MULT, with HI = bits 63:32 and LO = bits 31:0.
REQ-021 DIV and DIVU SHALL write LO=quotient and HI=remainder; signed quotient truncates toward zero and the signed remainder takes the sign of the dividend.
REQ-022 Divide by zero (signed or unsigned) SHALL give LO=0xFFFFFFFF and HI=rs_data, with normal latency.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-024 MTHI/MTLO SHALL write rs_data into hi/lo at the accepting edge, without asserting busy or done.
REQ-025 Reserved opcodes SHALL be accepted with no effect on any state.
REQ-026 hi and lo SHALL hold their previous values throughout busy; no partial results SHALL be visible.

Reset
REQ-027 When reset=1 at a rising edge: state -> IDLE; hi=0, lo=0, busy=0, done=0; any in-flight operation is discarded and never signals done.
REQ-028 reset SHALL take priority over a simultaneous op_valid; the op is not accepted.

Configuration
REQ-029 Macro MULDIV_FAST_MULT_EN SHALL select the multiply implementation.
REQ-030 With MULDIV_FAST_MULT_EN defined, MULT/MULTU SHALL go IDLE->FIXUP: a single-cycle 64-bit multiply written at E1, busy=1 for one cycle only, done high in the cycle after E1.
REQ-031 Without MULDIV_FAST_MULT_EN, multiply SHALL use the 33-edge iterative path; divide timing is identical in both builds.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done 33 cycles after accept (1 cycle with the macro defined).
REQ-033 MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064; a second op_valid held during busy is ignored and accepted only once op_ready=1.
REQ-036 MTLO 0x12345678 while idle -> lo=0x12345678 after 1 edge with no done pulse; MTHI issued mid-DIV -> no change to hi.
REQ-037 reset asserted at iteration 10 of a DIV -> next cycle busy=0, hi=lo=0, and done is never asserted for that DIV.
